// File: rtl/frog_game_ctrl.sv
// Frog game-state controller: per-frame car collision scan, goal detect,
// lives/score/level bookkeeping and frog respawn pulse.
module frog_game_ctrl #(
  parameter int NUM_CARS     = 8,
  parameter int FROG_SIZE    = 32,
  parameter int CAR_W        = 64,
  parameter int INIT_LIVES   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic [9:0]              frog_x,
  input  logic [9:0]              frog_y,
  input  logic [10*NUM_CARS-1:0]  car_x,
  input  logic [10*NUM_CARS-1:0]  car_y,
  output logic                    frog_reset,
  output logic [2:0]              state,
  output logic [1:0]              lives,
  output logic [7:0]              score,
  output logic [3:0]              level,
  output logic                    game_over
);

  localparam int IW   = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int MAXF = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES
                                                    : WIN_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  localparam logic [IW-1:0] LAST   = IW'(NUM_CARS - 1);
  localparam logic [CW-1:0] DEAD_N = CW'(DEATH_FRAMES);
  localparam logic [CW-1:0] WIN_N  = CW'(WIN_FRAMES);
  localparam logic [1:0]    LIVES0 = 2'(INIT_LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_SCAN = 3'd2,
    S_DEAD = 3'd3,
    S_WIN  = 3'd4,
    S_OVER = 3'd5
  } state_e;

  state_e        state_q;
  logic          frog_reset_q;
  logic [1:0]    lives_q;
  logic [7:0]    score_q;
  logic [3:0]    level_q;
  logic          game_over_q;
  logic [IW-1:0] idx_q;
  logic          hit_q;
  logic [CW-1:0] cnt_q;
  logic          start_prev_q;

  logic [9:0]    cx;
  logic [9:0]    cy;
  logic          hit_now;
  logic          hit_d;
  logic [CW-1:0] cnt_d;
  logic          start_edge;

  // 11-bit sums keep the overlap test free of wrap near x=1023
  always_comb begin
    cx      = car_x[10*int'(idx_q) +: 10];
    cy      = car_y[10*int'(idx_q) +: 10];
    hit_now = (cy == frog_y) &&
              ({1'b0, frog_x} < ({1'b0, cx} + 11'(CAR_W))) &&
              ({1'b0, cx} < ({1'b0, frog_x} + 11'(FROG_SIZE)));
    hit_d      = hit_q | hit_now;
    cnt_d      = cnt_q + 1'b1;
    start_edge = start & ~start_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frog_reset_q <= 1'b0;
      lives_q      <= LIVES0;
      score_q      <= 8'd0;
      level_q      <= 4'd0;
      game_over_q  <= 1'b0;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start;
      frog_reset_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            lives_q      <= LIVES0;
            score_q      <= 8'd0;
            level_q      <= 4'd0;
            game_over_q  <= 1'b0;
            frog_reset_q <= 1'b1;
            state_q      <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (frog_y == 10'd0) begin
              state_q <= S_WIN;
              cnt_q   <= '0;
              if (score_q != 8'hFF) score_q <= score_q + 8'd1;
              if (level_q != 4'hF)  level_q <= level_q + 4'd1;
            end else begin
              hit_q   <= 1'b0;
              idx_q   <= '0;
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          hit_q <= hit_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cnt_q <= '0;
            if (hit_d) begin
              state_q <= S_DEAD;
              if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
            end else begin
              state_q <= S_PLAY;
            end
          end
        end
        S_DEAD: begin
          if (frame_tick) begin
            cnt_q <= cnt_d;
            if (cnt_d == DEAD_N) begin
              if (lives_q == 2'd0) begin
                state_q     <= S_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q      <= S_PLAY;
                frog_reset_q <= 1'b1;
              end
            end
          end
        end
        S_WIN: begin
          if (frame_tick) begin
            cnt_q <= cnt_d;
            if (cnt_d == WIN_N) begin
              state_q      <= S_PLAY;
              frog_reset_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frog_reset = frog_reset_q;
  assign state      = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign level      = level_q;
  assign game_over  = game_over_q;

endmodule
